// File: rtl/cpu_pkg.sv
// Shared phase encodings for the CPU phase sequencer and its helpers.
package cpu_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'h0,
        DECODE   = 4'h1,
        EXEC     = 4'h2,
        MEM      = 4'h3,
        WB       = 4'h4,
        HALTED   = 4'h5,
        MC_WAIT  = 4'h6,
        FAULT    = 4'h7,
        JFETCH   = 4'h9,
        RST_WAIT = 4'hF
    } phase_e;

    // Phases that may hold on an external event and therefore count stall cycles.
    function automatic logic is_stall_phase(input phase_e p);
        return (p == FETCH) || (p == JFETCH) || (p == MEM) || (p == MC_WAIT);
    endfunction

endpackage

// File: rtl/prio_onehot.sv
// Lowest-index-wins one-hot select: isolates the least significant set bit.
module prio_onehot #(
    parameter int N_UNITS = 2
) (
    input  logic [N_UNITS-1:0] req,
    output logic [N_UNITS-1:0] grant
);

    // Two's complement trick: req & -req keeps only the lowest set bit.
    assign grant = req & (~req + N_UNITS'(1));

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Multicycle CPU phase sequencer: settle after reset, fetch/decode/exec/mem/wb,
// multicycle-unit handshake, stall counting with timeout fault.
module cpu_phase_sequencer
    import cpu_pkg::*;
#(
    parameter int N_UNITS      = 2,
    parameter int RESET_CYCLES = 2,
    parameter int CNT_W        = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wait_request,
    input  logic               jump,
    input  logic               halt,
    input  logic [N_UNITS-1:0] mc_req,
    input  logic [N_UNITS-1:0] mc_done,
    output logic [3:0]         state,
    output logic               active,
    output logic [N_UNITS-1:0] mc_start,
    output logic               fault,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic               instr_retired
);

    localparam int              SW          = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_V  = CNT_W'(TIMEOUT);

    phase_e              cur;
    phase_e              nxt;
    logic [SW-1:0]       settle_cnt;
    logic [N_UNITS-1:0]  unit_sel;
    logic [N_UNITS-1:0]  unit_latched;
    logic [CNT_W-1:0]    cnt;
    logic                timed_out;

    prio_onehot #(.N_UNITS(N_UNITS)) u_prio (
        .req   (mc_req),
        .grant (unit_sel)
    );

    // Only meaningful in a cycle that would otherwise hold the current stall phase.
    assign timed_out = (TIMEOUT != 0) && (cnt == TIMEOUT_V);

    always_comb begin
        nxt = cur;
        case (cur)
            RST_WAIT: if (settle_cnt == SETTLE_LAST) nxt = FETCH;
            FETCH: begin
                if (!wait_request) nxt = jump ? JFETCH : DECODE;
                else if (timed_out) nxt = FAULT;
            end
            JFETCH: begin
                if (!wait_request) nxt = EXEC;
                else if (timed_out) nxt = FAULT;
            end
            DECODE:  nxt = (mc_req != '0) ? MC_WAIT : EXEC;
            MC_WAIT: begin
                if ((mc_done & unit_latched) != '0) nxt = EXEC;
                else if (timed_out) nxt = FAULT;
            end
            EXEC: nxt = MEM;
            MEM: begin
                if (!wait_request) nxt = WB;
                else if (timed_out) nxt = FAULT;
            end
            WB:      nxt = halt ? HALTED : FETCH;
            HALTED:  nxt = HALTED;
            FAULT:   nxt = FAULT;
            default: nxt = FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur          <= RST_WAIT;
            settle_cnt   <= '0;
            unit_latched <= '0;
            cnt          <= '0;
        end else begin
            cur <= nxt;
            if (cur == RST_WAIT) settle_cnt <= settle_cnt + SW'(1);
            if (cur == DECODE) unit_latched <= unit_sel;
            if (nxt != cur) cnt <= '0;
            else if (is_stall_phase(cur) && (cnt != CNT_MAX)) cnt <= cnt + CNT_W'(1);
        end
    end

    // The stall counter is cleared on entry, so zero in MC_WAIT marks its first cycle.
    assign mc_start      = ((cur == MC_WAIT) && (cnt == '0)) ? unit_latched : '0;
    assign state         = cur;
    assign active        = (cur != HALTED) && (cur != FAULT);
    assign fault         = (cur == FAULT);
    assign instr_retired = (cur == WB);
    assign stall_cnt     = cnt;

endmodule

// File: doc/cpu_phase_sequencer.md
CPU_PHASE_SEQUENCER -- requirements
Module: cpu_phase_sequencer

Interface
REQ-001 SHALL take parameter N_UNITS, default 2: number of multicycle execution units (divider, multiplier, ...).
REQ-002 SHALL take parameter RESET_CYCLES, default 2: post-reset settle cycles, minimum 1.
REQ-003 SHALL take parameter CNT_W, default 8: stall counter width.
REQ-004 SHALL take parameter TIMEOUT, default 255: stall cycles before fault; 0 disables; value SHALL be <= 2^CNT_W-1.
REQ-005 SHALL have port clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-006 SHALL have port reset  in  1  synchronous active-high reset.
REQ-007 SHALL have port wait_request  in  1  memory-bus stall.
REQ-008 SHALL have port jump  in  1  jump/delay-slot fetch request, sampled in FETCH.
REQ-009 SHALL have port halt  in  1  halt request, sampled in WB.
REQ-010 SHALL have port mc_req  in  N_UNITS  decoded multicycle-unit request, sampled in DECODE.
REQ-011 SHALL have port mc_done  in  N_UNITS  per-unit completion.
REQ-012 SHALL have port state  out  4  current phase encoding.
REQ-013 SHALL have port active  out  1  CPU running.
REQ-014 SHALL have port mc_start  out  N_UNITS  one-cycle unit start pulse.
REQ-015 SHALL have port fault  out  1  sticky stall-timeout flag.
REQ-016 SHALL have port stall_cnt  out  CNT_W  cycles spent in the current stall.
REQ-017 SHALL have port instr_retired  out  1  high for the single WB cycle of each instruction.

Function
REQ-018 SHALL encode states RST_WAIT=4'hF, FETCH=4'h0, DECODE=4'h1, EXEC=4'h2, MEM=4'h3, WB=4'h4, HALTED=4'h5, MC_WAIT=4'h6, FAULT=4'h7, JFETCH=4'h9.
REQ-019 RST_WAIT SHALL last exactly RESET_CYCLES cycles, then go to FETCH.
REQ-020 FETCH: SHALL hold while wait_request=1; otherwise go to JFETCH if jump=1, else to DECODE.
REQ-021 JFETCH: SHALL hold while wait_request=1; otherwise go to EXEC, bypassing DECODE, with no unit start.
REQ-022 DECODE: SHALL go to MC_WAIT if mc_req!=0, else to EXEC; when several bits are set, the lowest index wins and SHALL be latched one-hot.
REQ-023 mc_start SHALL equal the latched one-hot only during the first MC_WAIT cycle, and 0 at all other times.
REQ-024 MC_WAIT: SHALL go to EXEC in the first cycle where (mc_done AND latched)!=0, including the mc_start cycle; mc_done bits of other units SHALL be ignored.
REQ-025 EXEC SHALL go to MEM unconditionally, ignoring wait_request.
REQ-026 MEM: SHALL hold while wait_request=1; otherwise go to WB.
REQ-027 WB SHALL never stall; it SHALL go to HALTED if halt=1, else to FETCH.
REQ-028 HALTED and FAULT SHALL be absorbing until reset.
REQ-029 active SHALL be 0 exactly when state is HALTED or FAULT; fault SHALL be 1 exactly when state is FAULT; instr_retired SHALL be 1 exactly when state is WB.
REQ-030 stall_cnt SHALL clear on every state change and increment each cycle the state holds in FETCH, JFETCH, MEM or MC_WAIT, saturating at 2^CNT_W-1.
REQ-031 With TIMEOUT!=0, a stalled cycle in which stall_cnt==TIMEOUT SHALL go to FAULT next, unless the stall releases in that same cycle.
REQ-032 All state and counter updates SHALL take effect on the rising clk edge; all outputs SHALL be Moore functions of registered state.

Reset
REQ-033 reset=1 SHALL override every other input, including mid-stall and mid-MC_WAIT.
REQ-034 Reset values SHALL be: state=RST_WAIT, active=1, mc_start=0, fault=0, stall_cnt=0, instr_retired=0, latched unit=0, settle counter=0.

Structure
REQ-035 State encodings and the state enum typedef SHALL reside in shared package cpu_pkg.
REQ-036 The lowest-index one-hot select SHALL be a sub-module named prio_onehot, parameterised by N_UNITS.

Verification
REQ-037 The bench SHALL check that reset released with RESET_CYCLES=2 and no stalls gives states F,F,0,1,2,3,4,0 and instr_retired high in cycle 7 only.
REQ-038 The bench SHALL check that jump=1 in FETCH gives FETCH->JFETCH->EXEC with mc_start never asserted.
REQ-039 The bench SHALL check that mc_req=2'b11 in DECODE latches 2'b01, pulses mc_start=2'b01 once, ignores mc_done=2'b10, and moves to EXEC one cycle after mc_done=2'b01.
REQ-040 The bench SHALL check that with TIMEOUT=5 and wait_request held in MEM, stall_cnt counts 0..5, state reaches FAULT next, and fault=1, active=0.
REQ-041 The bench SHALL check that halt=1 in WB gives HALTED with active=0, and that a later reset returns to RST_WAIT with active=1.
REQ-042 The bench SHALL check that reset asserted on the 3rd MC_WAIT cycle gives all outputs at reset values on the next cycle.
